// File: rtl/spi_controller.sv
// SPI Mode 0 register-write controller: serialises one 16-bit frame
// {write, addr[6:0], data[7:0]} MSB-first on sclk/mosi/cs_n per accepted request.
module spi_controller #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic [2:0] state_dbg
);

  // Handshake: a request is taken on any rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE and inputs are ignored once taken.

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_SHIFT_HI = 3'd2,
    S_SHIFT_LO = 3'd3,
    S_GAP      = 3'd4
  } state_t;

  localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  phase;
  logic [7:0]  gap_cnt;
  logic [3:0]  bit_cnt;
  logic [14:0] shreg;
  logic        phase_last;
  logic        gap_last;
  logic        fall_edge;

  assign phase_last = (phase == PHASE_LAST);
  assign gap_last   = (gap_cnt == GAP_LAST);
  assign fall_edge  = (state == S_SHIFT_HI) && (state_nxt == S_SHIFT_LO);
  assign req_ready  = (state == S_IDLE);
  assign state_dbg  = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (req_valid)  state_nxt = S_SETUP;
      S_SETUP:    if (phase_last) state_nxt = S_SHIFT_HI;
      S_SHIFT_HI: if (phase_last) state_nxt = S_SHIFT_LO;
      // bit_cnt reads 0 in SHIFT_LO only after the 16th high phase wrapped it
      S_SHIFT_LO: if (phase_last) state_nxt = (bit_cnt == 4'd0) ? S_GAP : S_SHIFT_HI;
      S_GAP:      if (gap_last)   state_nxt = S_IDLE;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      phase   <= 8'd0;
      gap_cnt <= 8'd0;
      bit_cnt <= 4'd0;
      shreg   <= 15'd0;
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state || state_nxt == S_IDLE || state_nxt == S_GAP)
        phase <= 8'd0;
      else
        phase <= phase + 8'd1;

      if (state == S_GAP && state_nxt == S_GAP)
        gap_cnt <= gap_cnt + 8'd1;
      else
        gap_cnt <= 8'd0;

      if (fall_edge)
        bit_cnt <= bit_cnt + 4'd1;

      // Outputs are registered from the next state so they change cleanly with it
      if (state == S_IDLE && req_valid) begin
        shreg <= {req_addr, req_data};
        mosi  <= req_write;
      end else if (fall_edge && bit_cnt != 4'd15) begin
        shreg <= {shreg[13:0], 1'b0};
        mosi  <= shreg[14];
      end else if (state_nxt == S_IDLE || state_nxt == S_GAP) begin
        mosi  <= 1'b0;
      end

      cs_n <= !(state_nxt == S_SETUP || state_nxt == S_SHIFT_HI || state_nxt == S_SHIFT_LO);
      sclk <= (state_nxt == S_SHIFT_HI);
      busy <= (state_nxt != S_IDLE);
      done <= (state_nxt == S_GAP) && (state != S_GAP);
    end
  end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
SPI Mode 0 controller that drives the chip's SPI register bus from the system-clock domain, for on-chip self-test and bring-up loopback. It accepts one 16-bit register-write request at a time over a valid/ready handshake and serialises it MSB-first on sclk/mosi/cs_n. Frame format: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data. Timing is sized so the spi_peripheral register block, with its 2-flop input synchronisers, captures every bit and commits on cs_n deassertion.

Parameters:
CLK_DIV, 4, sclk half-period in clk cycles; legal range 2..255; sclk period = 2*CLK_DIV.
GAP_CYCLES, 8, minimum cs_n-high cycles between frames; legal range 4..255.

Ports:
clk  in  1  system clock; all logic is on its rising edge
rst_n  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request; high only in IDLE
req_write  in  1  value driven on frame bit 15
req_addr  in  7  frame bits 14:8
req_data  in  8  frame bits 7:0
busy  out  1  high from the cycle after acceptance until the return to IDLE
done  out  1  one-cycle pulse at frame end
sclk  out  1  SPI clock; idles low
mosi  out  1  SPI data out; 0 when idle
cs_n  out  1  SPI chip select, active low; idles high

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, cs_n=1, sclk=0, mosi=0, busy=0, done=0, req_ready=1 after release, all counters=0. Reset has priority over everything.
- Reset mid-frame: outputs return to idle values at that same edge. The aborted frame is dropped, not retried, and done is not pulsed.
- Acceptance: occurs on an edge where req_valid && req_ready. The 16-bit frame {req_write, req_addr, req_data} is latched into a shift register. Input changes after acceptance have no effect.
- States: IDLE -> SETUP -> SHIFT_HI <-> SHIFT_LO -> GAP -> IDLE.
- IDLE: req_ready=1, cs_n=1, sclk=0, mosi=0. Acceptance moves to SETUP.
- SETUP: CLK_DIV cycles. cs_n=0, sclk=0, mosi=frame[15]; first cycle is the cycle after acceptance.
- SHIFT_HI: CLK_DIV cycles, sclk=1, mosi stable. The peripheral samples here.
- SHIFT_LO: CLK_DIV cycles, sclk=0.
  - On entry (falling sclk), mosi advances to the next bit, unless the 16th bit has just completed.
  - After the 16th SHIFT_LO (the hold phase), go to GAP.
- Bit counter: 4 bits, counts completed high phases 0..15. Wrap from 15 ends the frame and is not a new bit.
- Frame end:
  - cs_n rises on the first GAP cycle; sclk=0 and mosi=0 there.
  - done=1 for exactly that cycle.
  - GAP lasts GAP_CYCLES cycles, then IDLE with req_ready=1.
- Latency:
  - cs_n is low for exactly 33*CLK_DIV cycles.
  - Exactly 16 sclk rising edges per frame.
  - Acceptance-to-next-req_ready = 33*CLK_DIV + GAP_CYCLES + 1 cycles.
  - Back-to-back: with req_valid held, the next acceptance is on the first IDLE cycle.
- Phase counter width: 8 bits, counts 0..CLK_DIV-1. It never wraps beyond CLK_DIV-1.
- busy is high in SETUP, SHIFT_HI, SHIFT_LO and GAP.
- No glitches: sclk, mosi and cs_n are registered outputs.
- req_write=0 frames are transmitted identically. The peripheral ignores them, and the controller does not special-case them.

Test Plan:
1. Reset, then request write addr 0x04 data 0x80 (CLK_DIV=4, GAP=8) -> mosi sampled at 16 sclk rises = 0x8480 MSB-first; cs_n low 132 cycles; done pulses once at cs_n rise; a looped-back spi_peripheral shows pwm_duty_cycle=0x80.
2. Five back-to-back writes (addr 0x00..0x04, data 0xA5,0x5A,0xFF,0x01,0x3C) with req_valid held -> each re-acceptance exactly 141 cycles after the previous one; the peripheral registers end equal to those values.
3. Change req_addr/req_data and pulse req_valid while busy -> req_ready stays 0, no extra acceptance, transmitted frame unchanged.
4. Assert rst_n low for 1 cycle after 7 sclk rises -> the next edge gives cs_n=1, sclk=0, mosi=0, busy=0, no done; the peripheral registers are unchanged; a following request is accepted normally.
5. CLK_DIV=2, GAP_CYCLES=4, write addr 0x01 data 0xC3 -> cs_n low 66 cycles, ready after 71 cycles, the peripheral captures 0xC3 in en_reg_out_15_8.
6. req_write=0, addr 0x02, data 0xFF -> frame 0x02FF on mosi, done pulses, the peripheral's en_reg_pwm_7_0 stays 0x00.
